// File: rtl/rf_wport_sched_pkg.sv
// Shared core types (register address, 64-bit word) plus the writeback request bundle
// used by the register-file write-port scheduler.
package common;

    typedef logic [4:0]  creg_addr_t;
    typedef logic [63:0] u64;

    typedef struct packed {
        logic       valid;
        creg_addr_t dst;
        u64         data;
    } wb_req_t;

    localparam int NUM_WB_REQ = 3;

endpackage

// File: rtl/rf_wport_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, search starts at the pointer,
// pointer moves past the granted index only when the caller reports a transfer.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic          found;
    int            idx;

    // Scan N positions starting at ptr, wrapping modulo N; first requester wins.
    always_comb begin
        gnt      = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                ptr_next = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/rf_wport_sched.sv
// Integer regfile write-port scheduler: round-robin writeback arbitration, registered
// write stage and busy scoreboard for issue hazards. Optional counters: RF_WPORT_STATS_EN.
module rf_wport_sched
    import common::*;
#(
    parameter int NREQ  = NUM_WB_REQ,
    parameter int NREGS = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [NREQ-1:0]             req_valid,
    input  creg_addr_t [NREQ-1:0]       req_dst,
    input  u64 [NREQ-1:0]               req_data,
    output logic [NREQ-1:0]             req_ready,
    input  logic                        iss_valid,
    input  creg_addr_t                  iss_rs1,
    input  creg_addr_t                  iss_rs2,
    input  creg_addr_t                  iss_rd,
    input  logic                        iss_wen,
    output logic                        iss_stall,
    output logic                        rf_wvalid,
    output creg_addr_t                  rf_wa,
    output u64                          rf_wd,
    output logic [NREGS-1:0]            sb_busy
`ifdef RF_WPORT_STATS_EN
    ,
    output logic [31:0]                 stat_conflict,
    output logic [31:0]                 stat_stall
`endif
);

    logic [NREQ-1:0]  req_eligible;
    logic             xfer;
    wb_req_t          sel;
    logic             set_en;
    logic [NREGS-1:0] busy_next;
    logic             rs1_busy;
    logic             rs2_busy;
    logic             rd_busy;

    // Flush suppresses all grants, so the pointer cannot move during a flush cycle.
    assign req_eligible = req_valid & {NREQ{~flush}};

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_eligible),
        .advance (xfer),
        .gnt     (req_ready)
    );

    assign xfer = |req_ready;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel.valid = 1'b1;
                sel.dst   = req_dst[i];
                sel.data  = req_data[i];
            end
        end
    end

    // Writes to x0 are consumed but never reach the regfile port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_wvalid <= 1'b0;
            rf_wa     <= '0;
            rf_wd     <= '0;
        end else if (flush) begin
            rf_wvalid <= 1'b0;
        end else begin
            rf_wvalid <= sel.valid && (sel.dst != '0);
            if (sel.valid) begin
                rf_wa <= sel.dst;
                rf_wd <= sel.data;
            end
        end
    end

    assign rs1_busy  = (iss_rs1 != '0) && sb_busy[iss_rs1];
    assign rs2_busy  = (iss_rs2 != '0) && sb_busy[iss_rs2];
    assign rd_busy   = (iss_rd  != '0) && sb_busy[iss_rd];
    assign iss_stall = iss_valid && (rs1_busy || rs2_busy || (iss_wen && rd_busy));
    assign set_en    = iss_valid && !iss_stall && iss_wen && (iss_rd != '0);

    // Clear is applied before set so a same-register collision leaves the bit set.
    always_comb begin
        busy_next = sb_busy;
        if (rf_wvalid) begin
            busy_next[rf_wa] = 1'b0;
        end
        if (set_en) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            sb_busy <= '0;
        end else begin
            sb_busy <= busy_next;
        end
    end

`ifdef RF_WPORT_STATS_EN
    // Free-running, wrapping counters; flush deliberately leaves them untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_conflict <= '0;
            stat_stall    <= '0;
        end else begin
            if ($countones(req_valid) >= 2) begin
                stat_conflict <= stat_conflict + 32'd1;
            end
            if (iss_stall) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_wport_sched.sv
// Directed self-checking bench for rf_wport_sched; counter checks enabled with RF_WPORT_STATS_EN.
module tb_rf_wport_sched;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [2:0]       req_valid;
    logic [2:0][4:0]  req_dst;
    logic [2:0][63:0] req_data;
    logic [2:0]       req_ready;
    logic             iss_valid;
    logic [4:0]       iss_rs1;
    logic [4:0]       iss_rs2;
    logic [4:0]       iss_rd;
    logic             iss_wen;
    logic             iss_stall;
    logic             rf_wvalid;
    logic [4:0]       rf_wa;
    logic [63:0]      rf_wd;
    logic [31:0]      sb_busy;
`ifdef RF_WPORT_STATS_EN
    logic [31:0]      stat_conflict;
    logic [31:0]      stat_stall;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_wport_sched dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_dst   (req_dst),
        .req_data  (req_data),
        .req_ready (req_ready),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_wen   (iss_wen),
        .iss_stall (iss_stall),
        .rf_wvalid (rf_wvalid),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .sb_busy   (sb_busy)
`ifdef RF_WPORT_STATS_EN
        ,
        .stat_conflict (stat_conflict),
        .stat_stall    (stat_stall)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] v, input logic [4:0] d0, input logic [4:0] d1,
                                 input logic [4:0] d2, input logic [63:0] x0, input logic [63:0] x1,
                                 input logic [63:0] x2);
        req_valid   = v;
        req_dst[0]  = d0;
        req_dst[1]  = d1;
        req_dst[2]  = d2;
        req_data[0] = x0;
        req_data[1] = x1;
        req_data[2] = x2;
        #1;
    endtask

    task automatic applyIssue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic wen);
        iss_valid = v;
        iss_rs1   = rs1;
        iss_rs2   = rs2;
        iss_rd    = rd;
        iss_wen   = wen;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
        applyIssue(1'b0, 0, 0, 0, 1'b0);
        step();
        step();
        checkOutput("rst_wvalid", rf_wvalid, 0);
        checkOutput("rst_wa", rf_wa, 0);
        checkOutput("rst_wd", rf_wd, 0);
        checkOutput("rst_busy", sb_busy, 0);
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_stall", iss_stall, 0);
        reset = 1'b0;

        // Single ALU write, one-cycle latency to the port, single-cycle pulse
        applyStimulus(3'b001, 5, 0, 0, 64'h11, 0, 0);
        checkOutput("alu_ready", req_ready, 3'b001);
        step();
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
        checkOutput("alu_wvalid", rf_wvalid, 1);
        checkOutput("alu_wa", rf_wa, 5);
        checkOutput("alu_wd", rf_wd, 64'h11);
        step();
        checkOutput("alu_pulse", rf_wvalid, 0);

        // Round-robin from a fresh pointer with all requesters valid
        reset = 1'b1;
        step();
        reset = 1'b0;
        applyStimulus(3'b111, 1, 2, 3, 64'hA0, 64'hB0, 64'hC0);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("rr_gnt%0d", i), req_ready, 3'b001 << (i % 3));
            step();
            checkOutput($sformatf("rr_wvalid%0d", i), rf_wvalid, 1);
            checkOutput($sformatf("rr_wa%0d", i), rf_wa, (i % 3) + 1);
            checkOutput($sformatf("rr_wd%0d", i), rf_wd, 64'hA0 + 64'h10 * (i % 3));
        end
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);

        // RAW hazard on x7 until the write to 7 has been retired
        applyIssue(1'b1, 0, 0, 7, 1'b1);
        checkOutput("raw_nostall", iss_stall, 0);
        step();
        checkOutput("raw_busy7", sb_busy, 32'h80);
        applyIssue(1'b1, 7, 0, 0, 1'b0);
        checkOutput("raw_stall_a", iss_stall, 1);
        step();
        checkOutput("raw_stall_b", iss_stall, 1);
        applyStimulus(3'b010, 0, 7, 0, 0, 64'h77, 0);
        checkOutput("raw_lsu_ready", req_ready, 3'b010);
        step();
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
        checkOutput("raw_wvalid", rf_wvalid, 1);
        checkOutput("raw_wa", rf_wa, 7);
        checkOutput("raw_stall_c", iss_stall, 1);
        step();
        checkOutput("raw_busy_clr", sb_busy, 0);
        checkOutput("raw_released", iss_stall, 0);
        applyIssue(1'b0, 0, 0, 0, 1'b0);

        // x0 never busy and never written
        applyIssue(1'b1, 0, 0, 0, 1'b1);
        checkOutput("x0_nostall_a", iss_stall, 0);
        step();
        checkOutput("x0_busy", sb_busy, 0);
        applyIssue(1'b1, 0, 0, 0, 1'b0);
        checkOutput("x0_nostall_b", iss_stall, 0);
        applyStimulus(3'b001, 0, 0, 0, 64'h99, 0, 0);
        checkOutput("x0_ready", req_ready, 3'b001);
        step();
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
        applyIssue(1'b0, 0, 0, 0, 1'b0);
        checkOutput("x0_wvalid", rf_wvalid, 0);

        // Flush drops the pending write and clears the scoreboard
        applyIssue(1'b1, 0, 0, 3, 1'b1);
        step();
        applyIssue(1'b0, 0, 0, 0, 1'b0);
        checkOutput("fl_busy3", sb_busy, 32'h8);
        applyStimulus(3'b100, 0, 0, 3, 0, 0, 64'h33);
        checkOutput("fl_mdu_ready", req_ready, 3'b100);
        step();
        checkOutput("fl_pending", rf_wvalid, 1);
        flush = 1'b1;
        applyStimulus(3'b001, 6, 0, 0, 64'h66, 0, 0);
        checkOutput("fl_no_grant", req_ready, 0);
        step();
        flush = 1'b0;
        checkOutput("fl_busy_clr", sb_busy, 0);
        checkOutput("fl_wvalid", rf_wvalid, 0);
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);

        // Reset mid-operation returns pointer and state to initial values
        applyIssue(1'b1, 0, 0, 4, 1'b1);
        step();
        applyIssue(1'b0, 0, 0, 0, 1'b0);
        applyStimulus(3'b001, 4, 0, 0, 64'h44, 0, 0);
        step();
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("mid_busy", sb_busy, 0);
        checkOutput("mid_wvalid", rf_wvalid, 0);
        checkOutput("mid_wa", rf_wa, 0);
        checkOutput("mid_wd", rf_wd, 0);
        applyStimulus(3'b111, 1, 2, 3, 0, 0, 0);
        checkOutput("mid_ptr", req_ready, 3'b001);
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);

`ifdef RF_WPORT_STATS_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("st_rst_conf", stat_conflict, 0);
        checkOutput("st_rst_stall", stat_stall, 0);
        applyStimulus(3'b011, 1, 2, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
        applyIssue(1'b1, 0, 0, 9, 1'b1);
        step();
        applyIssue(1'b1, 9, 0, 0, 1'b0);
        step();
        step();
        applyIssue(1'b0, 0, 0, 0, 1'b0);
        step();
        checkOutput("st_conflict", stat_conflict, 4);
        checkOutput("st_stall", stat_stall, 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
